// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM state encoding and UART register map.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    // UART register block offsets
    localparam logic [11:0] TX_DATA = 12'h000;
    localparam logic [11:0] RX_DATA = 12'h004;
    localparam logic [11:0] CFG     = 12'h008;
    localparam logic [11:0] CTRL    = 12'h00C;
    localparam logic [11:0] STT     = 12'h010;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; expired pulses when an enabled count reaches LIMIT.
module apb_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW   = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
    localparam int unsigned LAST = (LIMIT == 0) ? 0 : LIMIT - 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

    // Flags the increment that would bring the count to LIMIT, so the abort
    // lands after exactly LIMIT stalled cycles.
    assign expired = (LIMIT != 0) && enable && (count == CW'(LAST));

endmodule

// File: rtl/apb_master.sv
// APB4 requester: valid/ready command in, SETUP/ACCESS transfer out, valid/ready response back.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_strb_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic [DATA_W-1:0]   pwdata_o,
    output logic [DATA_W/8-1:0] pstrb_o,
    input  logic [DATA_W-1:0]   prdata_i,
    input  logic                pready_i,
    input  logic                pslverr_i
);

    apb_state_e state;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       cnt_expired;

    assign cmd_ready_o = (state == IDLE);
    assign cnt_clear   = (state == IDLE) && cmd_valid_i;
    assign cnt_enable  = (state == ACCESS) && !pready_i;

    apb_timeout_cnt #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        psel_o   <= 1'b1;
                        pwrite_o <= cmd_write_i;
                        paddr_o  <= cmd_addr_i;
                        pwdata_o <= cmd_wdata_i;
                        pstrb_o  <= cmd_write_i ? cmd_strb_i : '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // Completion is checked first so a late pready beats the timeout.
                    if (pready_i) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                        rsp_err_o     <= pslverr_i;
                        rsp_timeout_o <= 1'b0;
                        state         <= RESP;
                    end else if (cnt_expired) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= '0;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: drives commands and a scripted APB slave, checks against hand-derived values.
module tb_apb_master;
    import apb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [11:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o, rsp_timeout_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [11:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [31:0] prdata_i;
    logic        pready_i, pslverr_i;

    int checks = 0;
    int errors = 0;

    apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a command for one accept edge; leaves the bench in SETUP.
    task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0; cmd_strb_i = '0; rsp_ready_i = 1'b0; prdata_i = '0;
        pready_i = 1'b0; pslverr_i = 1'b0;
        tick(); tick();
        check("rst_psel", 32'(psel_o), 0);
        check("rst_penable", 32'(penable_o), 0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_paddr", 32'(paddr_o), 0);
        check("rst_cmd_ready", 32'(cmd_ready_o), 1);
        reset_n = 1'b1;
        tick();

        // Zero-wait write to CFG
        pready_i = 1'b1;
        issue(1'b1, CFG, 32'h0000_001B, 4'hF);
        check("wr_setup_psel", 32'(psel_o), 1);
        check("wr_setup_penable", 32'(penable_o), 0);
        check("wr_paddr", 32'(paddr_o), 32'h8);
        check("wr_pwdata", pwdata_o, 32'h1B);
        check("wr_pstrb", 32'(pstrb_o), 32'hF);
        check("wr_pwrite", 32'(pwrite_o), 1);
        check("wr_cmd_ready_busy", 32'(cmd_ready_o), 0);
        tick();
        check("wr_access_penable", 32'(penable_o), 1);
        check("wr_access_rsp_valid", 32'(rsp_valid_o), 0);
        tick();
        check("wr_rsp_valid", 32'(rsp_valid_o), 1);
        check("wr_rsp_err", 32'(rsp_err_o), 0);
        check("wr_rsp_rdata", rsp_rdata_o, 0);
        check("wr_resp_psel", 32'(psel_o), 0);
        handshake();
        check("wr_done_valid", 32'(rsp_valid_o), 0);
        check("wr_done_cmd_ready", 32'(cmd_ready_o), 1);

        // Read STT with three wait states
        pready_i = 1'b0;
        issue(1'b0, STT, 32'hFFFF_FFFF, 4'hF);
        check("rd_pstrb_zero", 32'(pstrb_o), 0);
        check("rd_pwrite", 32'(pwrite_o), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rd_wait_penable", 32'(penable_o), 1);
            check("rd_wait_paddr", 32'(paddr_o), 32'h10);
            check("rd_wait_rsp_valid", 32'(rsp_valid_o), 0);
            tick();
        end
        pready_i = 1'b1; prdata_i = 32'h5;
        check("rd_last_penable", 32'(penable_o), 1);
        check("rd_last_pstrb", 32'(pstrb_o), 0);
        tick();
        prdata_i = 32'h0;
        check("rd_rsp_valid", 32'(rsp_valid_o), 1);
        check("rd_rsp_rdata", rsp_rdata_o, 32'h5);
        check("rd_rsp_err", 32'(rsp_err_o), 0);
        check("rd_resp_penable", 32'(penable_o), 0);
        handshake();

        // Slave error on write to RX_DATA
        pready_i = 1'b1; pslverr_i = 1'b1;
        issue(1'b1, RX_DATA, 32'hA5, 4'h1);
        tick(); tick();
        pslverr_i = 1'b0;
        check("slverr_rsp_err", 32'(rsp_err_o), 1);
        check("slverr_rsp_timeout", 32'(rsp_timeout_o), 0);
        check("slverr_psel_low", 32'(psel_o), 0);
        handshake();

        // Timeout: pready never rises
        pready_i = 1'b0; prdata_i = 32'hFFFF_FFFF;
        issue(1'b0, TX_DATA, 32'h0, 4'h0);
        tick();
        for (int i = 0; i < 16; i++) begin
            check("to_access_psel", 32'(psel_o), 1);
            check("to_access_penable", 32'(penable_o), 1);
            tick();
        end
        check("to_psel_drop", 32'(psel_o), 0);
        check("to_rsp_valid", 32'(rsp_valid_o), 1);
        check("to_rsp_err", 32'(rsp_err_o), 1);
        check("to_rsp_timeout", 32'(rsp_timeout_o), 1);
        check("to_rsp_rdata", rsp_rdata_o, 0);
        handshake();
        prdata_i = 32'h0;

        // Normal transfer after timeout
        pready_i = 1'b1;
        issue(1'b1, CTRL, 32'h3, 4'h3);
        tick(); tick();
        check("post_to_valid", 32'(rsp_valid_o), 1);
        check("post_to_err", 32'(rsp_err_o), 0);
        check("post_to_timeout", 32'(rsp_timeout_o), 0);
        handshake();

        // pready arrives on the 16th ACCESS cycle: completion beats timeout
        pready_i = 1'b0;
        issue(1'b0, RX_DATA, 32'h0, 4'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("edge_still_access", 32'(penable_o), 1);
        pready_i = 1'b1; prdata_i = 32'h1234;
        tick();
        prdata_i = 32'h0;
        check("edge_rsp_valid", 32'(rsp_valid_o), 1);
        check("edge_rsp_timeout", 32'(rsp_timeout_o), 0);
        check("edge_rsp_err", 32'(rsp_err_o), 0);
        check("edge_rsp_rdata", rsp_rdata_o, 32'h1234);
        handshake();

        // Response backpressure with a pending command
        pready_i = 1'b1; prdata_i = 32'hDEAD_BEEF;
        issue(1'b0, RX_DATA, 32'h0, 4'h0);
        tick(); tick();
        prdata_i = 32'h0;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = CTRL;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid_o), 1);
            check("bp_rsp_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
            check("bp_cmd_ready", 32'(cmd_ready_o), 0);
            check("bp_psel", 32'(psel_o), 0);
            tick();
        end
        handshake();
        cmd_valid_i = 1'b0;
        check("bp_done_valid", 32'(rsp_valid_o), 0);
        check("bp_done_cmd_ready", 32'(cmd_ready_o), 1);
        check("bp_done_psel", 32'(psel_o), 0);

        // Reset during ACCESS wait states
        pready_i = 1'b0;
        issue(1'b0, STT, 32'h0, 4'h0);
        tick(); tick();
        check("mid_pre_penable", 32'(penable_o), 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_psel", 32'(psel_o), 0);
        check("mid_rst_penable", 32'(penable_o), 0);
        check("mid_rst_paddr", 32'(paddr_o), 0);
        check("mid_rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("mid_rst_cmd_ready", 32'(cmd_ready_o), 1);
        reset_n = 1'b1; pready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_after_rsp_valid", 32'(rsp_valid_o), 0);
            check("mid_after_psel", 32'(psel_o), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
